// File: rtl/gear_shift_if.sv
// Gear selector bus: driver-side inputs and gear/status outputs.
// master drives engine/button/brake/speed; slave (controller) returns gear status.
interface gear_shift_if;
   logic       engine_on;
   logic       btn_up;
   logic       btn_down;
   logic       is_brake_normal;
   logic       is_brake_hard;
   logic [7:0] speed;
   logic [3:0] current_gear;
   logic       shifting;
   logic       shift_done;
   logic       shift_reject;

   modport master (
      output engine_on, btn_up, btn_down,
      output is_brake_normal, is_brake_hard, speed,
      input  current_gear, shifting, shift_done, shift_reject
   );

   modport slave (
      input  engine_on, btn_up, btn_down,
      input  is_brake_normal, is_brake_hard, speed,
      output current_gear, shifting, shift_done, shift_reject
   );
endinterface

// File: rtl/gear_shift_controller.sv
// Gear shift controller: debounced buttons, interlocked timed shifts P/R/N/D.
// Ports: clk, rst (async active-low), bus (gear_shift_if.slave).
module gear_shift_controller #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SHIFT_DELAY     = 8
) (
   input logic        clk,
   input logic        rst,
   gear_shift_if.slave bus
);

   localparam logic [3:0]  G_P = 4'd3;
   localparam logic [3:0]  G_R = 4'd6;
   localparam logic [3:0]  G_N = 4'd9;
   localparam logic [3:0]  G_D = 4'd12;
   localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0]  DLY_LOAD = 8'(SHIFT_DELAY - 1);

   typedef enum logic {IDLE, SHIFTING} state_t;

   // index 0 = up, index 1 = down
   logic [1:0]       s1, s2, deb, press;
   logic [1:0][15:0] cnt;

   state_t     state;
   logic [3:0] gear, target;
   logic [7:0] dly;
   logic       shifting, done, reject;

   logic       brake, stopped;
   logic [3:0] req_to;

   assign brake   = bus.is_brake_normal | bus.is_brake_hard;
   assign stopped = (bus.speed == 8'd0);

   function automatic logic [3:0] next_gear(input logic [3:0] g,
                                            input logic up);
      logic [3:0] n;
      n = g;
      unique case (1'b1)
         (g == G_P): n = up ? G_R : G_P;
         (g == G_R): n = up ? G_N : G_P;
         (g == G_N): n = up ? G_D : G_R;
         (g == G_D): n = up ? G_D : G_N;
         default:    n = g;
      endcase
      return n;
   endfunction

   // Same-gear moves (up in D, down in P) fall to the default and fail.
   function automatic logic legal(input logic [3:0] from,
                                  input logic [3:0] to,
                                  input logic br,
                                  input logic st);
      logic ok;
      ok = 1'b0;
      case ({from, to})
         {G_P, G_R}: ok = br & st;
         {G_R, G_P}: ok = br & st;
         {G_R, G_N}: ok = 1'b1;
         {G_N, G_R}: ok = st;
         {G_N, G_D}: ok = 1'b1;
         {G_D, G_N}: ok = 1'b1;
         default:    ok = 1'b0;
      endcase
      return ok;
   endfunction

   assign req_to = next_gear(gear, press[0]);

   // Press event is registered together with the debounced 0->1 flip.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1    <= '0;
         s2    <= '0;
         deb   <= '0;
         press <= '0;
         cnt   <= '0;
      end else begin
         s1 <= {bus.btn_down, bus.btn_up};
         s2 <= s1;
         for (int i = 0; i < 2; i++) begin
            press[i] <= 1'b0;
            if (s2[i] != deb[i]) begin
               if (cnt[i] == CNT_LAST) begin
                  deb[i]   <= s2[i];
                  cnt[i]   <= '0;
                  press[i] <= s2[i];
               end else begin
                  cnt[i] <= cnt[i] + 16'd1;
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         gear     <= G_P;
         target   <= G_P;
         dly      <= '0;
         shifting <= 1'b0;
         done     <= 1'b0;
         reject   <= 1'b0;
      end else begin
         done   <= 1'b0;
         reject <= 1'b0;
         if (!bus.engine_on) begin
            // Rolling with engine off: hold neutral until standstill.
            state    <= IDLE;
            shifting <= 1'b0;
            gear     <= stopped ? G_P : G_N;
         end else begin
            case (state)
               IDLE: begin
                  if (press[0] & press[1]) begin
                     reject <= 1'b1;
                  end else if (press[0] | press[1]) begin
                     if (legal(gear, req_to, brake, stopped)) begin
                        target   <= req_to;
                        dly      <= DLY_LOAD;
                        state    <= SHIFTING;
                        shifting <= 1'b1;
                     end else begin
                        reject <= 1'b1;
                     end
                  end
               end
               SHIFTING: begin
                  if (dly != 8'd0) begin
                     dly <= dly - 8'd1;
                  end else begin
                     state    <= IDLE;
                     shifting <= 1'b0;
                     if (legal(gear, target, brake, stopped)) begin
                        gear <= target;
                        done <= 1'b1;
                     end else begin
                        reject <= 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.current_gear = gear;
   assign bus.shifting     = shifting;
   assign bus.shift_done   = done;
   assign bus.shift_reject = reject;

endmodule

// File: tb/tb_gear_shift_controller.sv
// Directed bench for gear_shift_controller.
// Drives the gear_shift_if master side; checks gear, timing and pulses.
module tb_gear_shift_controller;

   localparam int DB  = 16;
   localparam int SD  = 8;
   localparam int LAT = 3 + DB + SD;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   gear_shift_if bus ();

   gear_shift_controller #(
      .DEBOUNCE_CYCLES (DB),
      .SHIFT_DELAY     (SD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic settle();
      bus.btn_up   = 1'b0;
      bus.btn_down = 1'b0;
      repeat (DB + 6) tick();
   endtask

   // Clean press; gear must change exactly LAT edges after the raw edge.
   task automatic do_shift(input logic up, input logic [3:0] from,
                           input logic [3:0] to);
      bus.btn_up   = up;
      bus.btn_down = ~up;
      repeat (LAT - 1) tick();
      chk("pre_gear", 8'(bus.current_gear), 8'(from));
      chk("pre_shifting", 8'(bus.shifting), 8'd1);
      tick();
      chk("gear", 8'(bus.current_gear), 8'(to));
      chk("done", 8'(bus.shift_done), 8'd1);
      chk("no_rej", 8'(bus.shift_reject), 8'd0);
      chk("shift_end", 8'(bus.shifting), 8'd0);
      tick();
      chk("done_1cyc", 8'(bus.shift_done), 8'd0);
      settle();
   endtask

   task automatic do_reject(input logic up, input logic dn,
                            input logic [3:0] g);
      bus.btn_up   = up;
      bus.btn_down = dn;
      repeat (2 + DB) tick();
      chk("rej_early", 8'(bus.shift_reject), 8'd0);
      tick();
      chk("rej", 8'(bus.shift_reject), 8'd1);
      chk("rej_no_done", 8'(bus.shift_done), 8'd0);
      chk("rej_gear", 8'(bus.current_gear), 8'(g));
      tick();
      chk("rej_1cyc", 8'(bus.shift_reject), 8'd0);
      chk("rej_idle", 8'(bus.shifting), 8'd0);
      settle();
   endtask

   initial begin
      checks              = 0;
      errors              = 0;
      rst                 = 1'b0;
      bus.engine_on       = 1'b0;
      bus.btn_up          = 1'b0;
      bus.btn_down        = 1'b0;
      bus.is_brake_normal = 1'b0;
      bus.is_brake_hard   = 1'b0;
      bus.speed           = 8'd0;
      tick();
      tick();
      chk("rst_gear", 8'(bus.current_gear), 8'd3);
      chk("rst_shifting", 8'(bus.shifting), 8'd0);
      chk("rst_done", 8'(bus.shift_done), 8'd0);
      chk("rst_rej", 8'(bus.shift_reject), 8'd0);
      rst                 = 1'b1;
      bus.engine_on       = 1'b1;
      bus.is_brake_normal = 1'b1;
      tick();

      do_shift(1'b1, 4'd3, 4'd6);
      do_shift(1'b1, 4'd6, 4'd9);
      do_shift(1'b1, 4'd9, 4'd12);
      do_reject(1'b1, 1'b0, 4'd12);

      bus.speed           = 8'd60;
      bus.is_brake_normal = 1'b0;
      do_shift(1'b0, 4'd12, 4'd9);
      do_reject(1'b0, 1'b1, 4'd9);

      bus.speed         = 8'd0;
      bus.is_brake_hard = 1'b1;
      do_shift(1'b0, 4'd9, 4'd6);
      do_shift(1'b0, 4'd6, 4'd3);
      do_reject(1'b0, 1'b1, 4'd3);
      do_reject(1'b1, 1'b1, 4'd3);
      bus.is_brake_hard = 1'b0;
      do_reject(1'b1, 1'b0, 4'd3);

      // Bouncing up button, then held.
      bus.is_brake_normal = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.btn_up = ~bus.btn_up;
         repeat (3) tick();
      end
      bus.btn_up = 1'b1;
      repeat (LAT - 1) tick();
      chk("bnc_pre", 8'(bus.current_gear), 8'd3);
      tick();
      chk("bnc_gear", 8'(bus.current_gear), 8'd6);
      chk("bnc_done", 8'(bus.shift_done), 8'd1);
      repeat (DB + 10) tick();
      chk("bnc_once", 8'(bus.current_gear), 8'd6);
      chk("bnc_idle", 8'(bus.shifting), 8'd0);
      settle();
      do_shift(1'b0, 4'd6, 4'd3);

      // Interlock fails during SHIFTING: abort.
      bus.btn_up = 1'b1;
      repeat (3 + DB) tick();
      chk("ab_shifting", 8'(bus.shifting), 8'd1);
      bus.is_brake_normal = 1'b0;
      bus.speed           = 8'd1;
      repeat (SD - 1) tick();
      chk("ab_hold", 8'(bus.current_gear), 8'd3);
      tick();
      chk("ab_rej", 8'(bus.shift_reject), 8'd1);
      chk("ab_no_done", 8'(bus.shift_done), 8'd0);
      chk("ab_gear", 8'(bus.current_gear), 8'd3);
      chk("ab_idle", 8'(bus.shifting), 8'd0);
      tick();
      chk("ab_rej_1cyc", 8'(bus.shift_reject), 8'd0);
      settle();

      // Engine off while moving in D.
      bus.is_brake_normal = 1'b1;
      bus.speed           = 8'd0;
      do_shift(1'b1, 4'd3, 4'd6);
      do_shift(1'b1, 4'd6, 4'd9);
      do_shift(1'b1, 4'd9, 4'd12);
      bus.is_brake_normal = 1'b0;
      bus.speed           = 8'd30;
      tick();
      bus.engine_on = 1'b0;
      tick();
      chk("eoff_n", 8'(bus.current_gear), 8'd9);
      chk("eoff_no_done", 8'(bus.shift_done), 8'd0);
      bus.btn_up = 1'b1;
      repeat (DB + 6) tick();
      chk("eoff_press", 8'(bus.current_gear), 8'd9);
      chk("eoff_idle", 8'(bus.shifting), 8'd0);
      bus.speed = 8'd0;
      tick();
      chk("eoff_p", 8'(bus.current_gear), 8'd3);
      settle();
      bus.engine_on = 1'b1;
      tick();
      chk("eon_gear", 8'(bus.current_gear), 8'd3);
      chk("eon_idle", 8'(bus.shifting), 8'd0);

      // Async reset in the middle of R->N.
      bus.is_brake_normal = 1'b1;
      do_shift(1'b1, 4'd3, 4'd6);
      bus.btn_up = 1'b1;
      repeat (3 + DB + 3) tick();
      chk("mid_shifting", 8'(bus.shifting), 8'd1);
      chk("mid_gear", 8'(bus.current_gear), 8'd6);
      #2;
      rst        = 1'b0;
      bus.btn_up = 1'b0;
      #1;
      chk("arst_gear", 8'(bus.current_gear), 8'd3);
      chk("arst_shifting", 8'(bus.shifting), 8'd0);
      chk("arst_done", 8'(bus.shift_done), 8'd0);
      chk("arst_rej", 8'(bus.shift_reject), 8'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      do_shift(1'b1, 4'd3, 4'd6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
